shift_reg_n: RTL and testbench
==============================

# shift_reg_n

Parametrised universal shift register, the multi-bit successor to the single-bit enable/clear D flip-flop. It holds a WIDTH-bit word with true and complement outputs and supports load, shift, rotate and arithmetic-shift operations under an enable. An auto-shift sequencer performs a counted burst of shifts with busy/done status. It sits between datapath registers and serial links as a serializer/deserializer and general barrel-free shifter.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of burst count input; must hold WIDTH
- RESET_VAL, 0, value loaded into q on clear
- clk  input  1  rising-edge clock
- clear  input  1  reset; synchronous, active-high
- en  input  1  clock enable for all register updates except clear
- mode  input  3  operation select
- d  input  WIDTH  parallel load data
- sin  input  1  serial input bit for SHL/SHR
- start  input  1  request auto-shift burst
- cnt  input  CNT_W  number of shifts in burst
- q  output  WIDTH  register contents
- qb  output  WIDTH  bitwise complement of q, always ~q
- sout  output  1  last bit ejected by a shift/rotate
- busy  output  1  burst in progress
- done  output  1  one-cycle burst-complete pulse

## Operation
- Modes: 000 HOLD; 001 LOAD (q←d); 010 SHL (q←{q[W-2:0],sin}, eject q[W-1]); 011 SHR (q←{sin,q[W-1:1]}, eject q[0]); 100 ROL; 101 ROR; 110 ASR (MSB replicated, eject q[0]); 111 ZERO (q←0).
- Every shift/rotate updates sout with the ejected bit; LOAD/HOLD/ZERO leave sout unchanged.
- Clear dominates everything: q←RESET_VAL, qb←~RESET_VAL, sout←0, FSM→IDLE, busy=0, done=0. Independent of en.
- en=0: no change to q, qb, sout, or burst counter (FSM holds state).
- FSM states IDLE, RUN, DONE:
  - IDLE: with en=1 and start=0, mode applies directly. With en=1, start=1 and mode in 010–110: latch mode and cnt; no shift this edge; go to RUN if cnt≠0, otherwise DONE. start with any other mode is ignored, and mode then applies as a manual op.
  - RUN: each en=1 edge applies the latched op and decrements remaining. The edge that performs the last shift moves to DONE. mode, start, d and cnt are ignored.
  - DONE: lasts one cycle, then returns to IDLE unconditionally. It ignores start and en, and q holds.
- busy=1 exactly while in RUN; done=1 exactly while in DONE. Both are registered.
- cnt>WIDTH is legal; rotates wrap, and shifts fill completely with sin or the sign bit.

## Timing
- Manual op: result on q/qb/sout one edge after the en=1 sample.
- Burst: start accepted at edge k. busy is high after edge k. Shifts occur at the next cnt en-high edges. busy falls and done rises after the final shift edge, and done falls one edge later. Minimum burst with en held high is cnt+1 cycles, start to done.
- cnt=0: done is high in the cycle after acceptance; busy is never asserted and q is unchanged.
- Clear mid-burst: the next cycle is IDLE with q=RESET_VAL; no done pulse.
- Back-to-back: a new start is accepted at the earliest in the IDLE cycle after DONE.

## Structure
- Package shift_reg_pkg: mode encodings (MODE_HOLD … MODE_ZERO) and FSM state encoding (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module shift_op: combinational; inputs q, sin, op; outputs next q and ejected bit. It is shared by the manual path and the burst path.
- Top: FSM, down-counter (CNT_W bits), latched op register, q/sout registers. qb is derived as ~q.

## Test plan
- Reset: with q=0xA5 and en=0, clear=1 for one edge -> q=0x00, qb=0xFF, sout=0, busy=0, done=0.
- Enable gating: en=1, LOAD d=0x96 -> q=0x96, qb=0x69. Then en=0, LOAD d=0xFF -> q stays 0x96.
- Ops from q=0x81: SHL sin=1 -> q=0x03, sout=1. Then ROR -> q=0x81, sout=1. Then ASR -> q=0xC0, sout=1. Then ZERO -> q=0x00, sout=1.
- Burst: q=0xB4, start, mode=SHR, cnt=3, sin=0, en=1 -> q steps 0x5A, 0x2D, 0x16 with sout 0,0,1. busy is high for 3 cycles, followed by a 1-cycle done.
- Stall/abort: the same burst with en=0 for 2 cycles mid-run -> busy is high for 5 cycles and the final q=0x16. A separate run with clear asserted after the 2nd shift -> q=0x00 next cycle, IDLE, no done.
- Edge cases: start with cnt=0 -> done the next cycle, busy never high, q unchanged. start with mode=LOAD -> no burst, and q←d as a manual load. start while in RUN -> ignored.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes, burst FSM
// states, and a helper that identifies the operations a burst may run.
package shift_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_ZERO = 3'b111
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Shifts and rotates eject a bit and are the only ops a burst may repeat.
   function automatic logic is_shift_op(mode_t op);
      return (op == MODE_SHL) || (op == MODE_SHR) || (op == MODE_ROL) ||
             (op == MODE_ROR) || (op == MODE_ASR);
   endfunction

endpackage

// File: rtl/shift_reg_n_if.sv
// Control/data bundle of the shift register; master drives the controls,
// slave (the register) drives the word and burst status.
interface shift_reg_n_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   import shift_reg_pkg::*;

   logic             en;
   mode_t            mode;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             sout;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, d, sin, start, cnt,
      input  q, qb, sout, busy, done
   );

   modport slave (
      input  en, mode, d, sin, start, cnt,
      output q, qb, sout, busy, done
   );

endinterface

// File: rtl/shift_reg_n_shift_op.sv
// Combinational shift/rotate unit shared by the manual and burst paths.
// Non-shift ops pass q through and report a zero ejected bit.
module shift_op
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic             sin,
   input  mode_t            op,
   output logic [WIDTH-1:0] q_next,
   output logic             eject
);

   always_comb begin
      q_next = q;
      eject  = 1'b0;
      case (op)
         MODE_SHL: begin
            q_next = {q[WIDTH-2:0], sin};
            eject  = q[WIDTH-1];
         end
         MODE_SHR: begin
            q_next = {sin, q[WIDTH-1:1]};
            eject  = q[0];
         end
         MODE_ROL: begin
            q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            eject  = q[WIDTH-1];
         end
         MODE_ROR: begin
            q_next = {q[0], q[WIDTH-1:1]};
            eject  = q[0];
         end
         MODE_ASR: begin
            q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            eject  = q[0];
         end
         default: begin
            q_next = q;
            eject  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_n.sv
// Universal WIDTH-bit shift register with manual ops and a counted auto-shift
// burst sequencer (IDLE -> RUN -> DONE) reporting busy and a one-cycle done.
module shift_reg_n
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic        clk,
   input logic        clear,
   shift_reg_n_if.slave bus
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] q_r, q_nx;
   logic             sout_r, sout_nx;
   logic [CNT_W-1:0] rem_r, rem_nx;
   mode_t            op_r, op_nx;
   mode_t            active_op;
   logic [WIDTH-1:0] sh_q;
   logic             sh_bit;

   // During a burst the latched op drives the shifter; otherwise the live mode.
   assign active_op = (state == ST_RUN) ? op_r : bus.mode;

   shift_op #(.WIDTH(WIDTH)) u_shift_op (
      .q      (q_r),
      .sin    (bus.sin),
      .op     (active_op),
      .q_next (sh_q),
      .eject  (sh_bit)
   );

   always_comb begin
      state_nx = state;
      q_nx     = q_r;
      sout_nx  = sout_r;
      rem_nx   = rem_r;
      op_nx    = op_r;
      case (state)
         ST_IDLE: begin
            if (bus.en) begin
               if (bus.start && is_shift_op(bus.mode)) begin
                  op_nx    = bus.mode;
                  rem_nx   = bus.cnt;
                  state_nx = (bus.cnt != '0) ? ST_RUN : ST_DONE;
               end else begin
                  case (bus.mode)
                     MODE_HOLD: q_nx = q_r;
                     MODE_LOAD: q_nx = bus.d;
                     MODE_ZERO: q_nx = '0;
                     default: begin
                        q_nx    = sh_q;
                        sout_nx = sh_bit;
                     end
                  endcase
               end
            end
         end
         ST_RUN: begin
            if (bus.en) begin
               q_nx    = sh_q;
               sout_nx = sh_bit;
               rem_nx  = rem_r - CNT_W'(1);
               if (rem_r == CNT_W'(1)) begin
                  state_nx = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Clear wins over enable and abandons any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (clear) begin
         state  <= ST_IDLE;
         q_r    <= RESET_VAL;
         sout_r <= 1'b0;
         rem_r  <= '0;
         op_r   <= MODE_HOLD;
      end else begin
         state  <= state_nx;
         q_r    <= q_nx;
         sout_r <= sout_nx;
         rem_r  <= rem_nx;
         op_r   <= op_nx;
      end
   end

   assign bus.q    = q_r;
   assign bus.qb   = ~q_r;
   assign bus.sout = sout_r;
   assign bus.busy = (state == ST_RUN);
   assign bus.done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed plus randomized bench for shift_reg_n, checked against an
// arithmetic reference model of the register word and the burst bookkeeping.
module tb_shift_reg_n;
   import shift_reg_pkg::*;

   localparam int               WIDTH     = 8;
   localparam int               CNT_W     = 4;
   localparam int               TOP       = 1 << WIDTH;
   localparam int               HALF      = TOP / 2;
   localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

   logic clk = 1'b0;
   logic clear;

   always #5 clk = ~clk;

   shift_reg_n_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(RESET_VAL)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   int tests  = 0;
   int failed = 0;

   // Reference model: word as an integer, burst as shifts-left plus a done flag.
   int m_q    = 0;
   int m_sout = 0;
   int m_left = 0;
   int m_done = 0;
   int m_op   = 0;

   function automatic void model_op(int op, int s);
      case (op)
         2: begin m_sout = m_q / HALF; m_q = (m_q * 2) % TOP + s;        end
         3: begin m_sout = m_q % 2;    m_q = m_q / 2 + s * HALF;         end
         4: begin m_sout = m_q / HALF; m_q = (m_q * 2) % TOP + m_q / HALF; end
         5: begin m_sout = m_q % 2;    m_q = m_q / 2 + (m_q % 2) * HALF; end
         6: begin m_sout = m_q % 2;    m_q = m_q / 2 + (m_q >= HALF ? HALF : 0); end
         default: ;
      endcase
   endfunction

   task automatic model_edge();
      int md;
      md = int'(bus.mode);
      if (clear) begin
         m_q = int'(RESET_VAL); m_sout = 0; m_left = 0; m_done = 0;
      end else if (m_done != 0) begin
         m_done = 0;
      end else if (m_left > 0) begin
         if (bus.en) begin
            model_op(m_op, int'(bus.sin));
            m_left--;
            if (m_left == 0) m_done = 1;
         end
      end else if (bus.en) begin
         if (bus.start && md >= 2 && md <= 6) begin
            m_op   = md;
            m_left = int'(bus.cnt);
            if (m_left == 0) m_done = 1;
         end else if (md == 1) begin
            m_q = int'(bus.d);
         end else if (md == 7) begin
            m_q = 0;
         end else if (md != 0) begin
            model_op(md, int'(bus.sin));
         end
      end
   endtask

   task automatic check8(input string tag, input string field,
                         input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input string field,
                         input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check8(tag, "q",    bus.q,    8'(m_q));
      check8(tag, "qb",   bus.qb,   ~8'(m_q));
      check1(tag, "sout", bus.sout, 1'(m_sout));
      check1(tag, "busy", bus.busy, m_left > 0);
      check1(tag, "done", bus.done, m_done != 0);
   endtask

   task automatic applyStimulus(input string tag, input logic c, input logic e,
                                input mode_t m, input logic [7:0] dd,
                                input logic s, input logic st, input logic [3:0] n);
      clear     = c;
      bus.en    = e;
      bus.mode  = m;
      bus.d     = dd;
      bus.sin   = s;
      bus.start = st;
      bus.cnt   = n;
      model_edge();
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      clear = 1'b1; bus.en = 1'b0; bus.mode = MODE_HOLD; bus.d = '0;
      bus.sin = 1'b0; bus.start = 1'b0; bus.cnt = '0;

      applyStimulus("reset0", 1, 0, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("load_a5", 0, 1, MODE_LOAD, 8'hA5, 0, 0, 0);
      check8("load_a5", "q_const", bus.q, 8'hA5);
      applyStimulus("clear", 1, 0, MODE_LOAD, 8'hFF, 0, 0, 0);
      check8("clear", "q_const", bus.q, 8'h00);
      check8("clear", "qb_const", bus.qb, 8'hFF);

      applyStimulus("load_96", 0, 1, MODE_LOAD, 8'h96, 0, 0, 0);
      check8("load_96", "qb_const", bus.qb, 8'h69);
      applyStimulus("en_off", 0, 0, MODE_LOAD, 8'hFF, 0, 0, 0);
      check8("en_off", "q_const", bus.q, 8'h96);

      applyStimulus("load_81", 0, 1, MODE_LOAD, 8'h81, 0, 0, 0);
      applyStimulus("shl", 0, 1, MODE_SHL, 8'h00, 1, 0, 0);
      check8("shl", "q_const", bus.q, 8'h03);
      applyStimulus("ror", 0, 1, MODE_ROR, 8'h00, 0, 0, 0);
      check8("ror", "q_const", bus.q, 8'h81);
      applyStimulus("asr", 0, 1, MODE_ASR, 8'h00, 0, 0, 0);
      check8("asr", "q_const", bus.q, 8'hC0);
      applyStimulus("zero", 0, 1, MODE_ZERO, 8'h00, 0, 0, 0);
      check1("zero", "sout_const", bus.sout, 1'b1);

      // Plain burst, with a start/LOAD attempt mid-run that must be ignored.
      applyStimulus("b_load", 0, 1, MODE_LOAD, 8'hB4, 0, 0, 0);
      applyStimulus("b_start", 0, 1, MODE_SHR, 8'h00, 0, 1, 4'd3);
      check1("b_start", "busy_const", bus.busy, 1'b1);
      applyStimulus("b_s1", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      check8("b_s1", "q_const", bus.q, 8'h5A);
      applyStimulus("b_s2", 0, 1, MODE_LOAD, 8'hFF, 0, 1, 4'd9);
      check8("b_s2", "q_const", bus.q, 8'h2D);
      applyStimulus("b_s3", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      check8("b_s3", "q_const", bus.q, 8'h16);
      check1("b_s3", "done_const", bus.done, 1'b1);
      applyStimulus("b_idle", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);

      // Stalled burst.
      applyStimulus("st_load", 0, 1, MODE_LOAD, 8'hB4, 0, 0, 0);
      applyStimulus("st_start", 0, 1, MODE_SHR, 8'h00, 0, 1, 4'd3);
      applyStimulus("st_s1", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("st_w1", 0, 0, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("st_w2", 0, 0, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("st_s2", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("st_s3", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      check8("st_s3", "q_const", bus.q, 8'h16);
      applyStimulus("st_idle", 0, 0, MODE_HOLD, 8'h00, 0, 0, 0);

      // Burst aborted by clear.
      applyStimulus("ab_load", 0, 1, MODE_LOAD, 8'hB4, 0, 0, 0);
      applyStimulus("ab_start", 0, 1, MODE_SHR, 8'h00, 0, 1, 4'd3);
      applyStimulus("ab_s1", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("ab_s2", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("ab_clr", 1, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      check1("ab_clr", "done_const", bus.done, 1'b0);
      applyStimulus("ab_after", 0, 0, MODE_HOLD, 8'h00, 0, 0, 0);

      // Zero-length burst, start with a non-shift mode, long wrapping rotate.
      applyStimulus("c0_load", 0, 1, MODE_LOAD, 8'h3C, 0, 0, 0);
      applyStimulus("c0_start", 0, 1, MODE_SHL, 8'h00, 1, 1, 4'd0);
      check1("c0_start", "done_const", bus.done, 1'b1);
      check8("c0_start", "q_const", bus.q, 8'h3C);
      applyStimulus("c0_idle", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      applyStimulus("sl_load", 0, 1, MODE_LOAD, 8'h77, 0, 1, 4'd5);
      check8("sl_load", "q_const", bus.q, 8'h77);
      applyStimulus("rl_load", 0, 1, MODE_LOAD, 8'h81, 0, 0, 0);
      applyStimulus("rl_start", 0, 1, MODE_ROL, 8'h00, 0, 1, 4'd10);
      for (int i = 0; i < 11; i++) begin
         applyStimulus("rl_run", 0, 1, MODE_HOLD, 8'h00, 0, 0, 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         applyStimulus("rand", ($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 3) != 0),
                       mode_t'(3'($urandom_range(0, 7))),
                       8'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                       4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
